// File: rtl/rect_fill_scheduler_pkg.sv
// Shared types for the rectangle fill scheduler.
//   fill_state_t : scheduler FSM states
//   rect_cmd_t   : one fill command (bounds + colour), carried at a fixed
//                  maximum width so any WIDTH/HEIGHT/COLOR_BITS instance of
//                  the scheduler can use the same type
//   normalise_rect : orders each bound pair and clamps it to the screen
package rect_fill_scheduler_pkg;

    localparam int CMD_COORD_BITS = 16;
    localparam int CMD_COLOR_BITS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } fill_state_t;

    typedef struct packed {
        logic [CMD_COORD_BITS-1:0] x0;
        logic [CMD_COORD_BITS-1:0] y0;
        logic [CMD_COORD_BITS-1:0] x1;
        logic [CMD_COORD_BITS-1:0] y1;
        logic [CMD_COLOR_BITS-1:0] color;
    } rect_cmd_t;

    function automatic logic [CMD_COORD_BITS-1:0] clamp_coord(
        input logic [CMD_COORD_BITS-1:0] v,
        input logic [CMD_COORD_BITS-1:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

    // Swap first, then clamp: a reversed pair that straddles the screen edge
    // still covers the visible part of the span.
    function automatic rect_cmd_t normalise_rect(
        input rect_cmd_t                 c,
        input logic [CMD_COORD_BITS-1:0] x_lim,
        input logic [CMD_COORD_BITS-1:0] y_lim
    );
        rect_cmd_t n;
        n = c;
        if (c.x0 > c.x1) begin
            n.x0 = c.x1;
            n.x1 = c.x0;
        end
        if (c.y0 > c.y1) begin
            n.y0 = c.y1;
            n.y1 = c.y0;
        end
        n.x0 = clamp_coord(n.x0, x_lim);
        n.x1 = clamp_coord(n.x1, x_lim);
        n.y0 = clamp_coord(n.y0, y_lim);
        n.y1 = clamp_coord(n.y1, y_lim);
        return n;
    endfunction

endpackage

// File: rtl/rect_fill_scheduler_counter_2d.sv
// Raster scan counter: x runs fastest from x_start to x_end, then y steps.
//   clk, rst : clock and synchronous load of (x_start, y_start)
//   en       : advance one position
//   x_start/x_end, y_start/y_end : inclusive scan bounds
//   x, y     : current position
//   last     : current position is (x_end, y_end)
module rect_fill_scheduler_counter_2d #(
    parameter int XW = 10,
    parameter int YW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [XW-1:0] x_start,
    input  logic [XW-1:0] x_end,
    input  logic [YW-1:0] y_start,
    input  logic [YW-1:0] y_end,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic x_wrap;
    logic y_wrap;

    assign x_wrap = (x == x_end);
    assign y_wrap = (y == y_end);
    assign last   = x_wrap && y_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= x_start;
            y <= y_start;
        end else if (en) begin
            if (x_wrap) begin
                x <= x_start;
                y <= y_wrap ? y_start : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rect_fill_scheduler.sv
// Round-robin scheduler that accepts rectangle fill commands from N_REQ
// requesters and streams the covered pixels, in raster order, to a
// framebuffer write port with a valid/ready handshake.
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/ready    : per-requester command handshake (ready only in IDLE)
//   req_x0/x1, y0/y1   : per-requester inclusive bounds, any order
//   req_color          : per-requester fill colour
//   req_done           : one-cycle completion pulse for the served requester
//   pix_valid/ready    : pixel write handshake
//   pix_x/y/color      : pixel write data
//   busy, active_id    : scheduler occupied / requester being served
//
// state | meaning
// IDLE  | wait for a request, grant round-robin after last_grant
// LOAD  | scan counter loads (xmin, ymin)
// FILL  | present pixels, advance on each accepted write
// DONE  | pulse req_done, remember the served requester
module rect_fill_scheduler
    import rect_fill_scheduler_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int WIDTH      = 640,
    parameter  int HEIGHT     = 480,
    parameter  int COLOR_BITS = 12,
    localparam int X_BITS     = $clog2(WIDTH),
    localparam int Y_BITS     = $clog2(HEIGHT),
    localparam int ID_BITS    = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*X_BITS-1:0]     req_x0,
    input  logic [N_REQ*X_BITS-1:0]     req_x1,
    input  logic [N_REQ*Y_BITS-1:0]     req_y0,
    input  logic [N_REQ*Y_BITS-1:0]     req_y1,
    input  logic [N_REQ*COLOR_BITS-1:0] req_color,
    output logic [N_REQ-1:0]            req_done,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    output logic [X_BITS-1:0]           pix_x,
    output logic [Y_BITS-1:0]           pix_y,
    output logic [COLOR_BITS-1:0]       pix_color,
    output logic                        busy,
    output logic [ID_BITS-1:0]          active_id
);

    fill_state_t state, state_nxt;

    logic [ID_BITS-1:0]    last_grant;
    logic [ID_BITS-1:0]    grant_id;
    logic                  grant_found;
    logic [ID_BITS-1:0]    cand;
    rect_cmd_t             cmd_in;
    rect_cmd_t             cmd_norm;

    logic [X_BITS-1:0]     xmin, xmax;
    logic [Y_BITS-1:0]     ymin, ymax;
    logic [COLOR_BITS-1:0] color_q;

    logic [X_BITS-1:0]     cnt_x;
    logic [Y_BITS-1:0]     cnt_y;
    logic                  cnt_last;
    logic                  cnt_rst;
    logic                  pix_fire;

    // Search starts one past the last served requester so nobody is served
    // twice while another is waiting. Held off during reset.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ID_BITS'((int'(last_grant) + i) % N_REQ);
            if (!grant_found && !rst && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        cmd_in       = '0;
        cmd_in.x0    = CMD_COORD_BITS'(req_x0[grant_id*X_BITS +: X_BITS]);
        cmd_in.x1    = CMD_COORD_BITS'(req_x1[grant_id*X_BITS +: X_BITS]);
        cmd_in.y0    = CMD_COORD_BITS'(req_y0[grant_id*Y_BITS +: Y_BITS]);
        cmd_in.y1    = CMD_COORD_BITS'(req_y1[grant_id*Y_BITS +: Y_BITS]);
        cmd_in.color = CMD_COLOR_BITS'(req_color[grant_id*COLOR_BITS +: COLOR_BITS]);
        cmd_norm     = normalise_rect(cmd_in, CMD_COORD_BITS'(WIDTH - 1),
                                      CMD_COORD_BITS'(HEIGHT - 1));
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        pix_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_found) begin
                    req_ready[grant_id] = 1'b1;
                    state_nxt           = ST_LOAD;
                end
            end
            ST_LOAD: state_nxt = ST_FILL;
            ST_FILL: begin
                pix_valid = 1'b1;
                if (pix_ready && cnt_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // req_done is registered out of DONE, so it appears the cycle after
    // DONE while the FSM is already back in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= ID_BITS'(N_REQ - 1);
            active_id  <= '0;
            xmin       <= '0;
            xmax       <= '0;
            ymin       <= '0;
            ymax       <= '0;
            color_q    <= '0;
            req_done   <= '0;
        end else begin
            state    <= state_nxt;
            req_done <= '0;
            if (state == ST_IDLE && grant_found) begin
                active_id <= grant_id;
                xmin      <= X_BITS'(cmd_norm.x0);
                xmax      <= X_BITS'(cmd_norm.x1);
                ymin      <= Y_BITS'(cmd_norm.y0);
                ymax      <= Y_BITS'(cmd_norm.y1);
                color_q   <= COLOR_BITS'(cmd_norm.color);
            end
            if (state == ST_DONE) begin
                req_done[active_id] <= 1'b1;
                last_grant          <= active_id;
            end
        end
    end

    assign pix_fire = pix_valid && pix_ready;
    assign cnt_rst  = rst || (state == ST_LOAD);

    rect_fill_scheduler_counter_2d #(
        .XW (X_BITS),
        .YW (Y_BITS)
    ) u_counter_2d (
        .clk     (clk),
        .rst     (cnt_rst),
        .en      (pix_fire),
        .x_start (xmin),
        .x_end   (xmax),
        .y_start (ymin),
        .y_end   (ymax),
        .x       (cnt_x),
        .y       (cnt_y),
        .last    (cnt_last)
    );

    // Pixel data is forced to zero outside FILL so idle outputs match reset.
    assign pix_x     = (state == ST_FILL) ? cnt_x   : '0;
    assign pix_y     = (state == ST_FILL) ? cnt_y   : '0;
    assign pix_color = (state == ST_FILL) ? color_q : '0;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_rect_fill_scheduler.sv
module tb_rect_fill_scheduler;

    localparam int N_REQ = 4;
    localparam int WIDTH = 640;
    localparam int HEIGHT = 480;
    localparam int CB = 12;
    localparam int XB = 10;
    localparam int YB = 9;
    localparam int IDB = 2;

    typedef logic [XB+YB+CB-1:0] pix_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_REQ-1:0]      req_valid = '0;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*XB-1:0]   req_x0 = '0, req_x1 = '0;
    logic [N_REQ*YB-1:0]   req_y0 = '0, req_y1 = '0;
    logic [N_REQ*CB-1:0]   req_color = '0;
    logic [N_REQ-1:0]      req_done;
    logic                  pix_valid;
    logic                  pix_ready = 1'b1;
    logic [XB-1:0]         pix_x;
    logic [YB-1:0]         pix_y;
    logic [CB-1:0]         pix_color;
    logic                  busy;
    logic [IDB-1:0]        active_id;

    rect_fill_scheduler #(
        .N_REQ(N_REQ), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .COLOR_BITS(CB)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
        .req_color(req_color), .req_done(req_done),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .busy(busy), .active_id(active_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Monitor: observes the DUT at the falling edge.
    pix_t             got_q[$];
    pix_t             exp_q[$];
    logic [N_REQ-1:0] hs_q[$];
    logic [N_REQ-1:0] hs_vec = '0;
    logic [N_REQ-1:0] done_vec = '0;
    int               hs_cnt = 0, hs_cyc = 0;
    int               done_cnt = 0, done_cyc = 0, first_pv = -1;
    int               ready_viol = 0, stall_viol = 0;
    logic             stalled = 1'b0;
    pix_t             stall_pix = '0;

    always @(negedge clk) begin
        if (pix_valid && pix_ready) got_q.push_back({pix_x, pix_y, pix_color});
        if (pix_valid && first_pv < 0) first_pv = cyc;
        if (|req_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_vec = req_done;
        end
        if (busy && |req_ready) ready_viol++;
        if (stalled && pix_valid && {pix_x, pix_y, pix_color} !== stall_pix) stall_viol++;
        stalled   = pix_valid && !pix_ready;
        stall_pix = {pix_x, pix_y, pix_color};
        if (|(req_valid & req_ready)) begin
            hs_cnt++;
            hs_cyc = cyc;
            hs_vec = req_valid & req_ready;
            hs_q.push_back(req_valid & req_ready);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        hs_q.delete();
        first_pv = -1;
        done_cnt = 0;
        hs_cnt   = 0;
    endtask

    task automatic set_req(input int id, input int x0, input int y0, input int x1,
                           input int y1, input int color);
        req_x0[id*XB +: XB]    = XB'(x0);
        req_x1[id*XB +: XB]    = XB'(x1);
        req_y0[id*YB +: YB]    = YB'(y0);
        req_y1[id*YB +: YB]    = YB'(y1);
        req_color[id*CB +: CB] = CB'(color);
    endtask

    // Reference: ordered, clamped span; every pixel of the rectangle, row by row.
    function automatic void build_expected(input int x0, input int y0, input int x1,
                                           input int y1, input int color);
        int xa, xb, ya, yb;
        xa = (x0 < x1) ? x0 : x1;
        xb = (x0 < x1) ? x1 : x0;
        ya = (y0 < y1) ? y0 : y1;
        yb = (y0 < y1) ? y1 : y0;
        if (xa > WIDTH - 1)  xa = WIDTH - 1;
        if (xb > WIDTH - 1)  xb = WIDTH - 1;
        if (ya > HEIGHT - 1) ya = HEIGHT - 1;
        if (yb > HEIGHT - 1) yb = HEIGHT - 1;
        exp_q.delete();
        for (int y = ya; y <= yb; y++)
            for (int x = xa; x <= xb; x++)
                exp_q.push_back({XB'(x), YB'(y), CB'(color)});
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            sample();
            if (!busy) ok = 1;
            tick();
        end
        check(tag, ok, 1);
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready low 3 cycles on 2nd pixel
    task automatic run_cmd(input string tag, input int id, input int x0, input int y0,
                           input int x1, input int y1, input int color, input int mode);
        bit ok;
        int t_acc;
        build_expected(x0, y0, x1, y1, color);
        clear_mon();
        set_req(id, x0, y0, x1, y1, color);
        req_valid[id] = 1'b1;
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            sample();
            if (hs_cnt > 0) ok = 1;
            tick();
        end
        req_valid[id] = 1'b0;
        t_acc = hs_cyc;
        // The command must already be latched; scramble the requester's inputs.
        set_req(id, $urandom_range(0, 1023), $urandom_range(0, 511),
                $urandom_range(0, 1023), $urandom_range(0, 511), $urandom);
        check({tag, "_hs"}, ok, 1);
        check({tag, "_grant"}, hs_vec, 64'(1) << id);
        ok = 0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = ($urandom_range(0, 3) != 0);
                default: pix_ready = !(first_pv >= 0 && cyc >= first_pv + 1 && cyc <= first_pv + 3);
            endcase
            sample();
            if (done_cnt > 0) ok = 1;
            tick();
        end
        pix_ready = 1'b1;
        check({tag, "_done_seen"}, ok, 1);
        check({tag, "_done_id"}, done_vec, 64'(1) << id);
        check({tag, "_first_pv"}, first_pv, t_acc + 2);
        if (mode == 0) check({tag, "_done_cyc"}, done_cyc, t_acc + 3 + exp_q.size());
        if (mode == 2) check({tag, "_done_cyc"}, done_cyc, t_acc + 6 + exp_q.size());
        sample();
        tick();
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_npix"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_pix%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        bit ok;

        // Reset holds everything quiet even with requests pending.
        rst       = 1'b1;
        req_valid = 4'(($urandom_range(1, 15)));
        tick();
        tick();
        sample();
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        req_valid = '0;
        rst       = 1'b0;
        sample();
        check("rst_done", req_done, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_active_id", active_id, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        check("rst_pix_color", pix_color, 0);
        tick();

        run_cmd("r0_2x2", 0, 0, 0, 1, 1, 'hABC, 0);
        run_cmd("stall", 1, 5, 3, 7, 3, $urandom_range(0, 4095), 2);
        check("stall_hold", stall_viol, 0);
        run_cmd("clamp_x", 2, 700, 10, 638, 11, $urandom_range(0, 4095), 0);
        run_cmd("clamp_y", 3, 20, 500, 22, 478, $urandom_range(0, 4095), 1);
        run_cmd("one_px", 1, 100, 200, 100, 200, $urandom_range(0, 4095), 0);

        // Round robin with every requester asking continuously.
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_req(i, 10 * i, 5, 10 * i, 5, i + 1);
        clear_mon();
        req_valid = '1;
        ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            sample();
            if (hs_q.size() >= 5) ok = 1;
            tick();
        end
        req_valid = '0;
        check("rr_count", hs_q.size(), 5);
        for (int k = 0; k < 5 && k < hs_q.size(); k++)
            check($sformatf("rr_grant%0d", k), hs_q[k], 64'(1) << (k % N_REQ));
        wait_idle("rr_idle");

        // Reset in the middle of a 100-pixel fill.
        clear_mon();
        set_req(2, 0, 0, 9, 9, 'h123);
        req_valid[2] = 1'b1;
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            sample();
            if (hs_cnt > 0) ok = 1;
            tick();
        end
        req_valid = '0;
        check("abort_hs", ok, 1);
        for (int k = 0; k < 20; k++) tick();
        sample();
        check("abort_pre_valid", pix_valid, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample();
        check("abort_busy", busy, 0);
        check("abort_pix_valid", pix_valid, 0);
        for (int k = 0; k < 10; k++) tick();
        check("abort_no_done", done_cnt, 0);
        clear_mon();
        req_valid = '1;
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            sample();
            if (hs_cnt > 0) ok = 1;
            tick();
        end
        req_valid = '0;
        check("abort_next_grant", hs_vec, 1);
        wait_idle("abort_idle");

        // Random commands with random backpressure.
        for (int n = 0; n < 12; n++) begin
            int x0, y0, x1, y1;
            x0 = $urandom_range(0, 1023);
            y0 = $urandom_range(0, 511);
            x1 = x0 + $urandom_range(0, 6) - 3;
            y1 = y0 + $urandom_range(0, 6) - 3;
            if (x1 < 0) x1 = 0;
            if (x1 > 1023) x1 = 1023;
            if (y1 < 0) y1 = 0;
            if (y1 > 511) y1 = 511;
            run_cmd($sformatf("rnd%0d", n), $urandom_range(0, N_REQ - 1), x0, y0, x1, y1,
                    $urandom_range(0, 4095), 1);
        end

        check("ready_only_idle", ready_viol, 0);
        check("stall_hold_all", stall_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
